// File: rtl/psram_arbiter.sv
// psram_arbiter
//   Shares one PSRAM command port between a high-priority video scanout
//   reader (VID) and a low-priority host port (HOST, read/write). HOST is
//   protected from starvation: once VID has been granted HOST_STARVE_LIMIT
//   times in a row while HOST waits, HOST wins the next arbitration.
//   One transaction is in flight at a time. A watchdog aborts a transaction
//   whose mem_done does not arrive within TIMEOUT_CYCLES and raises a sticky
//   timeout_err.
//
// Ports
//   sysclk, reset            : clock, synchronous active-high reset
//   vid_req/vid_addr         : VID read request (held until vid_ack)
//   vid_ack/vid_rvalid/rdata : VID accept pulse, read-data pulse and data
//   host_req/rw/addr/wdata   : HOST request (held until host_ack)
//   host_ack/rvalid/rdata    : HOST accept pulse, read-data pulse and data
//   host_wdone               : HOST write completion pulse
//   mem_valid/ready/rw/addr/wdata : command handshake to the PSRAM driver
//   mem_done/mem_rdata       : completion pulse and read data from driver
//   busy                     : arbiter not in IDLE
//   timeout_err              : sticky watchdog abort flag
//
// Optional build macro PSRAM_ARB_STATS_EN adds 16-bit saturating counters:
//   stat_vid_grants, stat_host_grants, stat_max_wait (longest HOST wait in
//   IDLE/ISSUE before host_ack).

module psram_arbiter #(
    parameter int unsigned HOST_STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [23:0] vid_addr,
    output logic        vid_ack,
    output logic        vid_rvalid,
    output logic [7:0]  vid_rdata,
    input  logic        host_req,
    input  logic        host_rw,
    input  logic [23:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic        host_rvalid,
    output logic [7:0]  host_rdata,
    output logic        host_wdone,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_rw,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_done,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
`ifdef PSRAM_ARB_STATS_EN
    output logic [15:0] stat_vid_grants,
    output logic [15:0] stat_host_grants,
    output logic [15:0] stat_max_wait,
`endif
    output logic        timeout_err
);

    localparam int unsigned WDOG_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned STARVE_W = (HOST_STARVE_LIMIT > 1) ? $clog2(HOST_STARVE_LIMIT + 1) : 1;
    localparam logic [WDOG_W-1:0]   WDOG_LAST  = WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(HOST_STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } state_t;

    state_t              state_q, state_d;
    logic                owner_host_q, owner_host_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                mem_rw_q, mem_rw_d;
    logic [23:0]         mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic [7:0]          vid_rdata_q, vid_rdata_d;
    logic [7:0]          host_rdata_q, host_rdata_d;
    logic                vid_rvalid_q, vid_rvalid_d;
    logic                host_rvalid_q, host_rvalid_d;
    logic                host_wdone_q, host_wdone_d;
    logic                terr_q, terr_d;
    logic                grant_vid, grant_host;

    always_comb begin
        state_d       = state_q;
        owner_host_d  = owner_host_q;
        starve_d      = starve_q;
        wdog_d        = wdog_q;
        mem_rw_d      = mem_rw_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        vid_rdata_d   = vid_rdata_q;
        host_rdata_d  = host_rdata_q;
        vid_rvalid_d  = 1'b0;
        host_rvalid_d = 1'b0;
        host_wdone_d  = 1'b0;
        terr_d        = terr_q;
        vid_ack       = 1'b0;
        host_ack      = 1'b0;
        grant_vid     = 1'b0;
        grant_host    = 1'b0;

        case (state_q)
            IDLE: begin
                grant_vid  = vid_req && !(host_req && (starve_q == STARVE_MAX));
                grant_host = host_req && !grant_vid;

                // Counter only tracks VID wins while HOST is actually waiting.
                if (!host_req || grant_host) begin
                    starve_d = '0;
                end else if (grant_vid && (starve_q != STARVE_MAX)) begin
                    starve_d = starve_q + STARVE_W'(1);
                end

                if (grant_vid) begin
                    mem_rw_d     = 1'b0;
                    mem_addr_d   = vid_addr;
                    mem_wdata_d  = '0;
                    owner_host_d = 1'b0;
                    state_d      = ISSUE;
                end else if (grant_host) begin
                    mem_rw_d     = host_rw;
                    mem_addr_d   = host_addr;
                    mem_wdata_d  = host_wdata;
                    owner_host_d = 1'b1;
                    state_d      = ISSUE;
                end
            end

            ISSUE: begin
                if (mem_ready) begin
                    vid_ack  = !owner_host_q;
                    host_ack = owner_host_q;
                    wdog_d   = '0;
                    state_d  = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                wdog_d = wdog_q + WDOG_W'(1);
                // A completion in the expiry cycle wins over the watchdog.
                if (mem_done) begin
                    if (!owner_host_q) begin
                        vid_rdata_d  = mem_rdata;
                        vid_rvalid_d = 1'b1;
                    end else if (mem_rw_q) begin
                        host_wdone_d = 1'b1;
                    end else begin
                        host_rdata_d  = mem_rdata;
                        host_rvalid_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (wdog_q == WDOG_LAST) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_host_q  <= 1'b0;
            starve_q      <= '0;
            wdog_q        <= '0;
            mem_rw_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            vid_rdata_q   <= '0;
            host_rdata_q  <= '0;
            vid_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_wdone_q  <= 1'b0;
            terr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_host_q  <= owner_host_d;
            starve_q      <= starve_d;
            wdog_q        <= wdog_d;
            mem_rw_q      <= mem_rw_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            vid_rdata_q   <= vid_rdata_d;
            host_rdata_q  <= host_rdata_d;
            vid_rvalid_q  <= vid_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
            host_wdone_q  <= host_wdone_d;
            terr_q        <= terr_d;
        end
    end

    assign mem_valid   = (state_q == ISSUE);
    assign busy        = (state_q != IDLE);
    assign mem_rw      = mem_rw_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign vid_rdata   = vid_rdata_q;
    assign vid_rvalid  = vid_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign host_wdone  = host_wdone_q;
    assign timeout_err = terr_q;

`ifdef PSRAM_ARB_STATS_EN
    logic [15:0] stat_vid_q, stat_vid_d;
    logic [15:0] stat_host_q, stat_host_d;
    logic [15:0] stat_max_q, stat_max_d;
    logic [15:0] hwait_q, hwait_d;

    always_comb begin
        stat_vid_d  = stat_vid_q;
        stat_host_d = stat_host_q;
        stat_max_d  = stat_max_q;
        hwait_d     = hwait_q;

        if (grant_vid && (stat_vid_q != '1)) begin
            stat_vid_d = stat_vid_q + 16'd1;
        end
        if (grant_host && (stat_host_q != '1)) begin
            stat_host_d = stat_host_q + 16'd1;
        end

        // Wait time covers cycles spent in IDLE/ISSUE before the ack cycle.
        if (host_ack) begin
            hwait_d = '0;
            if (hwait_q > stat_max_q) begin
                stat_max_d = hwait_q;
            end
        end else if (!host_req) begin
            hwait_d = '0;
        end else if ((state_q != WAIT_RSP) && (hwait_q != '1)) begin
            hwait_d = hwait_q + 16'd1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            stat_vid_q  <= '0;
            stat_host_q <= '0;
            stat_max_q  <= '0;
            hwait_q     <= '0;
        end else begin
            stat_vid_q  <= stat_vid_d;
            stat_host_q <= stat_host_d;
            stat_max_q  <= stat_max_d;
            hwait_q     <= hwait_d;
        end
    end

    assign stat_vid_grants  = stat_vid_q;
    assign stat_host_grants = stat_host_q;
    assign stat_max_wait    = stat_max_q;
`endif

endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: directed scenarios followed by randomized
// transactions, checked against a transaction-level model of the
// arbitration rule, the command fields and the response pulses.

module tb_psram_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned TMO   = 64;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [23:0] vid_addr;
    logic        vid_ack;
    logic        vid_rvalid;
    logic [7:0]  vid_rdata;
    logic        host_req;
    logic        host_rw;
    logic [23:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic        host_rvalid;
    logic [7:0]  host_rdata;
    logic        host_wdone;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_rw;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_done;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        timeout_err;

    psram_arbiter #(
        .HOST_STARVE_LIMIT(LIMIT),
        .TIMEOUT_CYCLES   (TMO)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .host_req   (host_req),
        .host_rw    (host_rw),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .host_wdone (host_wdone),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_done   (mem_done),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 sysclk = ~sysclk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Requester state owned by the bench
    bit          vid_pend, host_pend;
    logic [23:0] v_addr, h_addr;
    logic        h_rw;
    logic [7:0]  h_wdata;

    // Reference model
    int unsigned vwins;          // consecutive VID wins while HOST waited
    bit          exp_terr;
    bit          exp_vrv, exp_hrv, exp_hwd;
    logic [7:0]  m_vdata, m_hdata;
    bit          late_done;
    bit          rd_fix_en;
    logic [7:0]  rd_fix;
    string       gl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic done, input logic [7:0] rd);
        vid_req    = vid_pend;
        vid_addr   = v_addr;
        host_req   = host_pend;
        host_rw    = h_rw;
        host_addr  = h_addr;
        host_wdata = h_wdata;
        mem_ready  = rdy;
        mem_done   = done;
        mem_rdata  = rd;
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        check({tag, "_vid_rvalid"}, vid_rvalid, 0);
        check({tag, "_host_rvalid"}, host_rvalid, 0);
        check({tag, "_host_wdone"}, host_wdone, 0);
    endtask

    task automatic chk_cmd(input string tag, input bit whost);
        check({tag, "_mem_addr"}, mem_addr, whost ? h_addr : v_addr);
        check({tag, "_mem_rw"}, mem_rw, whost ? h_rw : 1'b0);
        if (whost && h_rw) check({tag, "_mem_wdata"}, mem_wdata, h_wdata);
    endtask

    task automatic wait_cycle();
        tick();
        drive(1'($urandom), 1'b0, 8'($urandom));
        check("wt_busy", busy, 1);
        check("wt_valid", mem_valid, 0);
        check("wt_vid_ack", vid_ack, 0);
        check("wt_host_ack", host_ack, 0);
        check("wt_terr", timeout_err, exp_terr);
        chk_quiet("wt");
    endtask

    task automatic raise_vid(input logic [23:0] a);
        vid_pend = 1'b1;
        v_addr   = a;
    endtask

    task automatic raise_host(input logic rw, input logic [23:0] a, input logic [7:0] d);
        host_pend = 1'b1;
        h_rw      = rw;
        h_addr    = a;
        h_wdata   = d;
    endtask

    task automatic do_reset();
        bit sv, sh;
        tick();
        reset = 1'b1;
        drive(1'($urandom), 1'b0, 8'($urandom));
        tick();
        reset = 1'b0;
        sv = vid_pend;
        sh = host_pend;
        vid_pend  = 1'b0;
        host_pend = 1'b0;
        // A late completion right after reset must be ignored.
        drive(1'b1, 1'b1, 8'h5A);
        vid_pend  = sv;
        host_pend = sh;
        check("rst_busy", busy, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_vid_rdata", vid_rdata, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_vid_ack", vid_ack, 0);
        check("rst_host_ack", host_ack, 0);
        chk_quiet("rst");
        vwins    = 0;
        exp_terr = 1'b0;
        exp_vrv  = 1'b0;
        exp_hrv  = 1'b0;
        exp_hwd  = 1'b0;
        m_vdata  = 8'h00;
        m_hdata  = 8'h00;
    endtask

    // One arbitration slot starting with an IDLE cycle; results of the
    // previous transaction are checked in that IDLE cycle.
    task automatic round(input int unsigned stall, input int unsigned dly,
                         input bit nodone, input bit spur, input bit abort);
        bit         whost;
        logic [7:0] rd;
        tick();
        drive(1'($urandom), late_done, 8'($urandom));
        late_done = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_valid", mem_valid, 0);
        check("vid_rvalid", vid_rvalid, exp_vrv);
        check("host_rvalid", host_rvalid, exp_hrv);
        check("host_wdone", host_wdone, exp_hwd);
        check("vid_rdata", vid_rdata, m_vdata);
        check("host_rdata", host_rdata, m_hdata);
        check("timeout_err", timeout_err, exp_terr);
        exp_vrv = 1'b0;
        exp_hrv = 1'b0;
        exp_hwd = 1'b0;
        if (!vid_pend && !host_pend) begin
            vwins = 0;
            return;
        end
        whost = host_pend && (!vid_pend || vwins == LIMIT);
        if (whost || !host_pend) vwins = 0;
        else if (vwins < LIMIT) vwins++;
        gl = {gl, whost ? "H" : "V"};

        for (int unsigned i = 0; i < stall; i++) begin
            tick();
            drive(1'b0, spur && (i == 0), 8'($urandom));
            check("iss_valid", mem_valid, 1);
            check("iss_busy", busy, 1);
            check("iss_vid_ack", vid_ack, 0);
            check("iss_host_ack", host_ack, 0);
            check("iss_terr", timeout_err, exp_terr);
            chk_cmd("iss", whost);
            chk_quiet("iss");
        end

        tick();
        drive(1'b1, 1'b0, 8'($urandom));
        check("acc_valid", mem_valid, 1);
        check("vid_ack", vid_ack, !whost);
        check("host_ack", host_ack, whost);
        chk_cmd("acc", whost);
        chk_quiet("acc");
        if (whost) host_pend = 1'b0;
        else vid_pend = 1'b0;

        if (abort) begin
            for (int unsigned k = 0; k < 3; k++) wait_cycle();
            do_reset();
            return;
        end

        if (nodone) begin
            for (int unsigned k = 0; k < TMO; k++) wait_cycle();
            exp_terr  = 1'b1;
            late_done = 1'b1;
        end else begin
            for (int unsigned k = 0; k < dly; k++) wait_cycle();
            tick();
            rd = rd_fix_en ? rd_fix : 8'($urandom);
            drive(1'($urandom), 1'b1, rd);
            check("done_busy", busy, 1);
            chk_quiet("done");
            if (!whost) begin
                exp_vrv = 1'b1;
                m_vdata = rd;
            end else if (h_rw) begin
                exp_hwd = 1'b1;
            end else begin
                exp_hrv = 1'b1;
                m_hdata = rd;
            end
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int unsigned sel;
        reset      = 1'b1;
        vid_req    = 1'b0;
        vid_addr   = '0;
        host_req   = 1'b0;
        host_rw    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        mem_ready  = 1'b0;
        mem_done   = 1'b0;
        mem_rdata  = '0;
        vid_pend   = 1'b0;
        host_pend  = 1'b0;
        v_addr     = '0;
        h_addr     = '0;
        h_rw       = 1'b0;
        h_wdata    = '0;
        late_done  = 1'b0;
        rd_fix_en  = 1'b0;
        rd_fix     = '0;
        gl         = "";

        do_reset();
        round(0, 0, 0, 0, 0);

        // Single VID read, done 10 cycles into the response wait
        raise_vid(24'h000100);
        rd_fix_en = 1'b1;
        rd_fix    = 8'hA5;
        round(0, 10, 0, 0, 0);
        rd_fix_en = 1'b0;
        round(0, 0, 0, 0, 0);

        // HOST write with a short stall and a stray mem_done during ISSUE
        raise_host(1'b1, 24'h123456, 8'h3C);
        round(2, 5, 0, 1, 0);
        round(0, 0, 0, 0, 0);

        // Long ISSUE stall
        raise_vid(24'h0ABCDE);
        round(50, 3, 0, 0, 0);

        // Watchdog timeout, then normal service with the error held
        raise_host(1'b0, 24'h00FFEE, 8'h00);
        round(1, 0, 1, 0, 0);
        raise_vid(24'h000200);
        round(0, 4, 0, 0, 0);
        // Completion in the final watchdog cycle still counts
        raise_host(1'b0, 24'h000300, 8'h00);
        round(0, TMO - 1, 0, 0, 0);
        round(0, 0, 0, 0, 0);

        // Build up starvation count, then reset during WAIT_RSP
        for (int i = 0; i < 4; i++) begin
            if (!vid_pend) raise_vid(24'($urandom));
            if (!host_pend) raise_host(1'($urandom), 24'($urandom), 8'($urandom));
            round(0, 2, 0, 0, i == 3);
        end

        // Continuous contention from a clean reset
        gl = "";
        for (int i = 0; i < 10; i++) begin
            if (!vid_pend) raise_vid(24'($urandom));
            if (!host_pend) raise_host(1'($urandom), 24'($urandom), 8'($urandom));
            round($urandom_range(0, 2), $urandom_range(0, 6), 0, 0, 0);
        end
        check("grant_seq", gl == "VVVVHVVVVH", 1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if (!vid_pend && $urandom_range(0, 99) < 55) raise_vid(24'($urandom));
            if (!host_pend && $urandom_range(0, 99) < 55)
                raise_host(1'($urandom), 24'($urandom), 8'($urandom));
            sel = $urandom_range(0, 99);
            round($urandom_range(0, 3), (sel < 5) ? TMO - 1 : $urandom_range(0, 12),
                  (sel >= 5) && (sel < 8), 1'($urandom), 0);
        end
        vid_pend  = 1'b0;
        host_pend = 1'b0;
        round(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Shares the single PSRAM command port (IPS6404L-SQ driver, idle state) between two requesters:
  - video scanout read port (VID, high priority);
  - host/bus port (HOST, read or write, low priority, starvation-protected).
- Sequences one transaction at a time.
- Watchdogs the memory response and reports a sticky timeout.

Parameters:
- HOST_STARVE_LIMIT, 4: max consecutive VID grants while HOST is pending before HOST is forced a grant.
- TIMEOUT_CYCLES, 1024: sysclk cycles allowed between command acceptance and mem_done before abort.

Ports:
- sysclk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- vid_req  in  1  VID read request; held with vid_addr until vid_ack.
- vid_addr  in  24  VID read address.
- vid_ack  out  1  one-cycle pulse: VID command accepted by memory.
- vid_rvalid  out  1  one-cycle pulse: vid_rdata valid.
- vid_rdata  out  8  VID read data.
- host_req  in  1  HOST request; held with host_rw/addr/wdata until host_ack.
- host_rw  in  1  1 = write, 0 = read.
- host_addr  in  24  HOST address.
- host_wdata  in  8  HOST write data.
- host_ack  out  1  one-cycle pulse: HOST command accepted.
- host_rvalid  out  1  one-cycle pulse: host_rdata valid (reads only).
- host_rdata  out  8  HOST read data.
- host_wdone  out  1  one-cycle pulse: HOST write completed.
- mem_valid  out  1  command valid to PSRAM driver.
- mem_ready  in  1  driver accepts command when mem_valid && mem_ready.
- mem_rw  out  1  1 = write.
- mem_addr  out  24  command address.
- mem_wdata  out  8  command write data.
- mem_done  in  1  one-cycle pulse: transaction complete (reads and writes).
- mem_rdata  in  8  read data, valid with mem_done.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky, set on watchdog abort; cleared only by reset.

Behaviour:
- Reset (synchronous):
  - state = IDLE; starve_cnt = 0; wdog = 0.
  - All pulses, mem_valid, busy and timeout_err = 0; mem_addr, mem_wdata, vid_rdata, host_rdata = 0.
- States:
  - IDLE: arbitration, as follows.
    - No request: stay in IDLE.
    - Only one requester active: grant it.
    - Both active: grant VID unless starve_cnt == HOST_STARVE_LIMIT, then grant HOST.
    - On grant: latch the winner's rw/addr/wdata into mem_* (VID forces rw = 0), record owner, go to ISSUE.
    - Cycle budget: one IDLE cycle per arbitration.
  - ISSUE:
    - mem_valid = 1; mem_* held stable.
    - On mem_ready: pulse the owner's ack in the same cycle, mem_valid drops next cycle, wdog = 0, go to WAIT_RSP.
    - No timeout in ISSUE; the driver may stall indefinitely.
  - WAIT_RSP:
    - wdog increments each cycle.
    - On mem_done:
      - VID owner: vid_rdata <= mem_rdata, pulse vid_rvalid.
      - HOST read: host_rdata <= mem_rdata, pulse host_rvalid.
      - HOST write: pulse host_wdone.
      - Then go to IDLE.
    - If wdog reaches TIMEOUT_CYCLES-1 without mem_done: set timeout_err, no rvalid/wdone pulse, go to IDLE.
    - mem_done arriving in the same cycle as timeout expiry counts as completion; timeout_err is not set.
- Starvation counter:
  - VID grant while host_req = 1: starve_cnt += 1, saturating at HOST_STARVE_LIMIT.
  - HOST grant: starve_cnt = 0.
  - host_req = 0 in IDLE: starve_cnt = 0.
- Latency, read with immediate mem_ready: req seen in IDLE (cycle 0) -> mem_valid cycle 1 -> ack cycle 1 -> rvalid 1 cycle after mem_done.
- Ordering and ignored inputs:
  - Requests arriving in a non-IDLE state wait and are evaluated at the next IDLE.
  - Requester inputs are ignored after ack.
  - mem_done outside WAIT_RSP is ignored.
- Reset mid-transaction: abandon immediately, all outputs to reset values; the driver is reset by the same signal.

Optional Feature:
- Macro PSRAM_ARB_STATS_EN adds three outputs, each a 16-bit saturating count, zeroed on reset:
  - stat_vid_grants: number of VID grants.
  - stat_host_grants: number of HOST grants.
  - stat_max_wait: maximum cycles any HOST request waited in IDLE/ISSUE before host_ack.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single VID read: vid_addr = 0x000100, mem_ready = 1, mem_done 10 cycles later with rdata 0xA5 -> vid_ack one pulse, vid_rvalid one pulse, vid_rdata = 0xA5, busy low after completion.
- HOST write: host_rw = 1, addr 0x123456, wdata 0x3C -> mem_rw = 1, mem_addr = 0x123456, mem_wdata = 0x3C; host_wdone pulse after mem_done; no host_rvalid.
- Contention: vid_req and host_req held high continuously, limit 4 -> grant sequence V V V V H V V V V H; host_ack every 5th transaction.
- ISSUE stall: mem_ready low for 50 cycles -> mem_valid and mem_addr stable throughout, no ack, timeout_err stays 0.
- Timeout: mem_done never asserted -> timeout_err = 1 exactly TIMEOUT_CYCLES cycles after acceptance, no rvalid, return to IDLE, next request serviced normally, timeout_err stays 1.
- Reset in WAIT_RSP: reset pulse one cycle -> busy = 0, mem_valid = 0, timeout_err = 0, starve_cnt = 0; a late mem_done produces no pulse.
